shared_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port on-chip RAM between NUM_MASTERS Avalon-MM processor masters. The RAM is 32-bit wide with 16-bit word addressing, byte enables and an unregistered output. The arbiter sits between the per-processor data masters and the RAM in the multi-processor system. It sequences each access (grant, issue, read-data return), supports per-master lock for back-to-back bursts, and drives the RAM chipselect/write/clken.

---
 rtl/shared_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_MASTERS Avalon-MM
// masters; each access runs grant -> issue -> (read-data return), with optional lock.
module shared_mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_address,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_byteenable,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_writedata,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic [DATA_W-1:0]                 m_readdata,
  output logic [NUM_MASTERS-1:0]            m_readdatavalid,
  output logic [ADDR_W-1:0]                 mem_address,
  output logic [DATA_W/8-1:0]               mem_byteenable,
  output logic                              mem_chipselect,
  output logic                              mem_write,
  output logic [DATA_W-1:0]                 mem_writedata,
  output logic                              mem_clken,
  input  logic [DATA_W-1:0]                 mem_readdata
);

  localparam int BE_W    = DATA_W / 8;
  localparam int GW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int LAST_I  = NUM_MASTERS - 1;
  localparam logic [GW-1:0] LAST_INIT = LAST_I[GW-1:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    w_next_grant;
  logic [GW-1:0]    r_last_grant;
  logic [GW-1:0]    w_next_last_grant;
  logic             r_locked;
  logic             w_next_locked;
  logic [NUM_MASTERS-1:0] w_req;
  logic             w_any_req;
  logic [GW-1:0]    w_rr_pick;

  assign w_req     = m_read | m_write;
  assign w_any_req = |w_req;

  // Round-robin pick: first requester after last_grant; the loop runs downwards
  // so the nearest requester is the one left standing.
  always_comb begin
    w_rr_pick = r_last_grant;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      int v_idx;
      v_idx     = (int'(r_last_grant) + k) % NUM_MASTERS;
      w_rr_pick = w_req[v_idx[GW-1:0]] ? v_idx[GW-1:0] : w_rr_pick;
    end
  end

  // State and arbitration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_INIT;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_grant      <= w_next_grant;
      r_last_grant <= w_next_last_grant;
      r_locked     <= w_next_locked;
    end
  end

  // Next-state and arbitration decisions.
  always_comb begin
    w_next_state      = r_state;
    w_next_grant      = r_grant;
    w_next_last_grant = r_last_grant;
    w_next_locked     = r_locked;
    case (r_state)
      ST_IDLE: begin
        if (r_locked && w_req[r_grant]) begin
          w_next_state = ST_ACCESS;
        end else if (w_any_req) begin
          w_next_grant  = w_rr_pick;
          w_next_locked = 1'b0;
          w_next_state  = ST_ACCESS;
        end else begin
          w_next_locked = 1'b0;
        end
      end
      ST_ACCESS: begin
        // A master that dropped its request here gets nothing and is not
        // counted as served.
        if (w_req[r_grant]) begin
          w_next_last_grant = r_grant;
          w_next_locked     = m_lock[r_grant];
          w_next_state      = m_write[r_grant] ? ST_IDLE : ST_RDATA;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RDATA: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Master and RAM side outputs, forced to their idle values while in reset.
  always_comb begin
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    m_readdata      = '0;
    mem_address     = '0;
    mem_byteenable  = '0;
    mem_writedata   = '0;
    mem_chipselect  = 1'b0;
    mem_write       = 1'b0;
    mem_clken       = 1'b0;
    if (reset) begin
      mem_clken = 1'b0;
    end else begin
      mem_clken = 1'b1;
      case (r_state)
        ST_ACCESS: begin
          if (w_req[r_grant]) begin
            mem_address            = m_address[r_grant*ADDR_W +: ADDR_W];
            mem_byteenable         = m_byteenable[r_grant*BE_W +: BE_W];
            mem_writedata          = m_writedata[r_grant*DATA_W +: DATA_W];
            mem_chipselect         = 1'b1;
            mem_write              = m_write[r_grant];
            m_waitrequest[r_grant] = 1'b0;
          end else begin
            mem_chipselect = 1'b0;
          end
        end
        ST_RDATA: begin
          m_readdata               = mem_readdata;
          m_readdatavalid[r_grant] = 1'b1;
        end
        default: begin
          mem_chipselect = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed plan steps plus random traffic, checked
// against a cycle-scheduled reference of the arbitration rules and a word memory.
module tb_shared_mem_arbiter;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct {
    bit          wr;
    bit          lock;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          gap;
  } op_t;
  typedef struct { int cyc; int m; } acc_t;
  typedef struct { int cyc; int m; logic [31:0] data; } rd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NM*AW-1:0] m_address;
  logic [NM*BW-1:0] m_byteenable;
  logic [NM-1:0]    m_read, m_write, m_lock;
  logic [NM*DW-1:0] m_writedata;
  logic [NM-1:0]    m_waitrequest, m_readdatavalid;
  logic [DW-1:0]    m_readdata;
  logic [AW-1:0]    mem_address;
  logic [BW-1:0]    mem_byteenable;
  logic             mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0]    mem_writedata;
  logic [DW-1:0]    mem_readdata;

  shared_mem_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata), .m_lock(m_lock),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Single-port RAM with registered q, as the arbiter expects to see it.
  bit [31:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= f_merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           mem_readdata     <= ram[mem_address];
    end
  end

  // Reference state: word memory, last served master, lock, and scheduled events.
  bit [31:0]   exp_mem [int];
  int          ref_last, idle_from, pa_cyc, pa_m, pr_cyc, pr_m;
  bit          ref_locked;
  logic [31:0] pr_data;

  op_t   mq [NM][$];
  op_t   cur [NM];
  bit    pres [NM];
  bit    acc_prev [NM];
  acc_t  acc_log [$];
  rd_t   rd_log [$];
  int    n_assert, n_fail, cyc;
  bit    rst_next;

  function automatic logic [31:0] rdmem(input logic [15:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 32'h0;
  endfunction

  function automatic bit busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < NM; i++) if (mq[i].size() > 0 || pres[i]) b = 1'b1;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic put(input int m, input bit wr, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] be, input bit lk, input int gap);
    op_t o;
    o.wr = wr; o.lock = lk; o.addr = a; o.data = d; o.be = be; o.gap = gap;
    mq[m].push_back(o);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NM; i++) begin
      m_read[i]                 = pres[i] && !cur[i].wr;
      m_write[i]                = pres[i] && cur[i].wr;
      m_lock[i]                 = pres[i] && cur[i].lock;
      m_address[i*AW +: AW]     = pres[i] ? cur[i].addr : 16'h0;
      m_byteenable[i*BW +: BW]  = pres[i] ? cur[i].be : 4'h0;
      m_writedata[i*DW +: DW]   = pres[i] ? cur[i].data : 32'h0;
    end
  endtask

  task automatic step();
    int acc_m, rv_m, w;
    logic [NM-1:0] exp_wait, exp_rv, req;
    logic [31:0] exp_rd;
    op_t h;
    @(posedge clk); #1; cyc++;
    reset = rst_next;
    if (rst_next) begin
      for (int i = 0; i < NM; i++) begin
        mq[i].delete(); pres[i] = 1'b0; acc_prev[i] = 1'b0;
      end
      ref_last = NM - 1; ref_locked = 1'b0; idle_from = cyc + 1; pa_cyc = -1; pr_cyc = -1;
    end else begin
      for (int i = 0; i < NM; i++) begin
        if (acc_prev[i]) pres[i] = 1'b0;
        acc_prev[i] = 1'b0;
        if (!pres[i] && mq[i].size() > 0) begin
          h = mq[i][0];
          if (h.gap > 0) begin
            h.gap = h.gap - 1; mq[i][0] = h;
          end else begin
            cur[i] = mq[i].pop_front(); pres[i] = 1'b1;
          end
        end
      end
    end
    drive_inputs();

    acc_m = -1; rv_m = -1; exp_rd = 32'h0;
    if (!rst_next) begin
      if (pr_cyc == cyc) begin rv_m = pr_m; exp_rd = pr_data; end
      if (pa_cyc == cyc) begin
        acc_m = pa_m; ref_last = acc_m; ref_locked = cur[acc_m].lock;
        if (cur[acc_m].wr) begin
          exp_mem[int'(cur[acc_m].addr)] = f_merge(rdmem(cur[acc_m].addr), cur[acc_m].data, cur[acc_m].be);
          idle_from = cyc + 1;
        end else begin
          pr_cyc = cyc + 1; pr_m = acc_m; pr_data = rdmem(cur[acc_m].addr); idle_from = cyc + 2;
        end
      end else if (cyc >= idle_from) begin
        for (int i = 0; i < NM; i++) req[i] = pres[i];
        w = -1;
        if (ref_locked && req[ref_last]) w = ref_last;
        else begin
          ref_locked = 1'b0;
          for (int k = 1; k <= NM; k++) if (w < 0 && req[(ref_last + k) % NM]) w = (ref_last + k) % NM;
        end
        if (w >= 0) begin pa_cyc = cyc + 1; pa_m = w; idle_from = 1 << 30; end
      end
    end
    exp_wait = '1; exp_rv = '0;
    if (acc_m >= 0) exp_wait[acc_m] = 1'b0;
    if (rv_m >= 0) exp_rv[rv_m] = 1'b1;

    #1;
    chk("waitrequest", m_waitrequest, exp_wait);
    chk("readdatavalid", m_readdatavalid, exp_rv);
    chk("readdata", m_readdata, exp_rd);
    chk("chipselect", mem_chipselect, acc_m >= 0);
    chk("clken", mem_clken, !rst_next);
    if (rst_next) begin
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_mem_address", mem_address, 16'h0);
    end else if (acc_m >= 0) begin
      chk("mem_write", mem_write, cur[acc_m].wr);
      chk("mem_address", mem_address, cur[acc_m].addr);
      chk("mem_byteenable", mem_byteenable, cur[acc_m].be);
      if (cur[acc_m].wr) chk("mem_writedata", mem_writedata, cur[acc_m].data);
    end
    for (int i = 0; i < NM; i++) begin
      if (pres[i] && !m_waitrequest[i]) begin
        acc_prev[i] = 1'b1;
        acc_log.push_back('{cyc: cyc, m: i});
      end
      if (m_readdatavalid[i]) rd_log.push_back('{cyc: cyc, m: i, data: m_readdata});
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (busy() && k < budget) begin step(); k++; end
    chk({tag, "_drained"}, busy(), 1'b0);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, rb, t0;
    bit got;
    logic [15:0] a;
    logic [NM-1:0] all_ones;
    all_ones = '1;
    n_assert = 0; n_fail = 0; cyc = 0;
    pa_cyc = -1; pr_cyc = -1; ref_last = NM - 1; ref_locked = 1'b0; idle_from = 0;
    for (int i = 0; i < NM; i++) begin pres[i] = 1'b0; acc_prev[i] = 1'b0; end
    drive_inputs();
    rst_next = 1'b1;
    repeat (3) step();
    rst_next = 1'b0;

    // m0 write then read-back at 0x0010
    base = acc_log.size(); rb = rd_log.size(); t0 = cyc + 1;
    put(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 0);
    put(0, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 0);
    drain("t1", 40);
    chk("t1_n_accepts", acc_log.size() - base, 2);
    chk("t1_wr_accept_cyc", acc_log[base].cyc, t0 + 1);
    chk("t1_rd_accept_cyc", acc_log[base+1].cyc, t0 + 3);
    chk("t1_n_rdata", rd_log.size() - rb, 1);
    chk("t1_rdata_master", rd_log[rb].m, 0);
    chk("t1_rdata_cyc", rd_log[rb].cyc, t0 + 4);
    chk("t1_rdata", rd_log[rb].data, 32'hDEADBEEF);

    // byte-enable merge by m1
    rb = rd_log.size();
    put(1, 1'b1, 16'h0010, 32'h12345678, 4'h3, 1'b0, 0);
    put(1, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 0);
    drain("t2", 40);
    chk("t2_rdata_master", rd_log[rb].m, 1);
    chk("t2_rdata", rd_log[rb].data, 32'hDEAD5678);

    // both masters request straight out of reset
    rst_next = 1'b1; repeat (2) step(); rst_next = 1'b0;
    base = acc_log.size(); t0 = cyc + 1;
    put(0, 1'b1, 16'h0001, 32'h11111111, 4'hF, 1'b0, 0);
    put(1, 1'b1, 16'h0002, 32'h22222222, 4'hF, 1'b0, 0);
    drain("t3", 40);
    chk("t3_first_m", acc_log[base].m, 0);
    chk("t3_first_cyc", acc_log[base].cyc, t0 + 1);
    chk("t3_second_m", acc_log[base+1].m, 1);
    chk("t3_second_cyc", acc_log[base+1].cyc, t0 + 3);

    // contention: 8 writes each, no lock
    base = acc_log.size(); t0 = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      put(0, 1'b1, 16'h0100 + 16'(k), $urandom, 4'hF, 1'b0, 0);
      put(1, 1'b1, 16'h0200 + 16'(k), $urandom, 4'hF, 1'b0, 0);
    end
    drain("t4", 100);
    chk("t4_n_accepts", acc_log.size() - base, 16);
    chk("t4_first_cyc", acc_log[base].cyc, t0 + 1);
    for (int k = 0; k < 16; k++) chk("t4_order", acc_log[base+k].m, k % 2);
    chk("t4_span", acc_log[base+15].cyc - acc_log[base].cyc, 30);

    // lock: m1 holds the RAM for 4 writes while m0 waits
    base = acc_log.size();
    for (int k = 0; k < 4; k++) put(1, 1'b1, 16'h0300 + 16'(k), $urandom, 4'hF, 1'b1, 0);
    for (int k = 0; k < 4; k++) put(0, 1'b1, 16'h0400 + 16'(k), $urandom, 4'hF, 1'b0, (k == 0) ? 1 : 0);
    drain("t5", 100);
    for (int k = 0; k < 4; k++) chk("t5_locked_m1", acc_log[base+k].m, 1);
    chk("t5_m0_after", acc_log[base+4].m, 0);
    chk("t5_m0_cyc", acc_log[base+4].cyc, acc_log[base+3].cyc + 2);

    // random mixed traffic on a small address window
    for (int n = 0; n < 150; n++) begin
      a = 16'h0020 + 16'($urandom_range(0, 7));
      put($urandom_range(0, NM - 1), 1'($urandom_range(0, 1)), a, $urandom,
          4'($urandom_range(1, 15)), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end
    drain("t6", 3000);

    // reset during the read-data cycle of an m0 read
    base = acc_log.size(); rb = rd_log.size();
    put(0, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin step(); got = (acc_log.size() > base); end
    chk("t7_read_accepted", got, 1'b1);
    rst_next = 1'b1; step(); rst_next = 1'b0;
    step();
    chk("t7_post_rst_wait", m_waitrequest, all_ones);
    chk("t7_post_rst_cs", mem_chipselect, 1'b0);
    chk("t7_no_rdata", rd_log.size() - rb, 0);
    put(1, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 0);
    drain("t7", 40);
    chk("t7_m1_rdata_master", rd_log[rb].m, 1);
    chk("t7_m1_rdata", rd_log[rb].data, 32'hDEAD5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
